// File: rtl/lvds_frame_aligner.sv
// rtl/lvds_frame_aligner.sv - LVDS receive frame aligner: header hunt, lock qualification, payload delimiting
module lvds_frame_aligner #(
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] HDR0          = 8'hEE,
    parameter logic [DATA_W-1:0] HDR1          = 8'h33,
    parameter int                PAYLOAD_LEN   = 124,
    parameter int                LOCK_CNT      = 3,
    parameter int                LOSS_CNT      = 2,
    parameter bit                PASS_UNLOCKED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              sof,
    output logic              eof,
    output logic              locked,
    output logic              hdr_err,
    output logic [15:0]       frame_cnt
);

    localparam int CW = $clog2(PAYLOAD_LEN + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_GOT0,
        S_PAYLOAD,
        S_EXP0,
        S_EXP1
    } state_t;

    state_t        state;
    logic [CW-1:0] idx;
    logic [3:0]    good_cnt;
    logic [3:0]    miss_cnt;
    logic          gate;

    logic       is_hdr0, is_hdr1;
    logic       free_hdr, chain_hdr, miss;
    logic       last_beat;
    logic [3:0] good_inc, miss_inc;
    logic       lock_hdr, lock_drop;

    always_comb begin
        is_hdr0   = (din == HDR0);
        is_hdr1   = (din == HDR1);
        free_hdr  = din_vld && (state == S_GOT0) && is_hdr1;
        chain_hdr = din_vld && (state == S_EXP1) && is_hdr1;
        miss      = din_vld && (((state == S_EXP0) && !is_hdr0) ||
                                ((state == S_EXP1) && !is_hdr1));
        last_beat = (idx == CW'(PAYLOAD_LEN - 1));
        good_inc  = (good_cnt == 4'(LOCK_CNT)) ? good_cnt : good_cnt + 4'd1;
        miss_inc  = (miss_cnt == 4'(LOSS_CNT)) ? miss_cnt : miss_cnt + 4'd1;
        // A free header sets good_cnt to 1, so it can only lock when LOCK_CNT is 1
        lock_hdr  = (free_hdr && (LOCK_CNT == 1)) ||
                    (chain_hdr && (good_inc == 4'(LOCK_CNT)));
        lock_drop = miss && locked && (miss_inc == 4'(LOSS_CNT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HUNT;
            idx       <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            gate      <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            locked    <= 1'b0;
            hdr_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            dout_vld <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            hdr_err  <= 1'b0;
            if (din_vld) begin
                case (state)
                    S_HUNT: begin
                        if (is_hdr0) state <= S_GOT0;
                    end
                    S_GOT0: begin
                        if (is_hdr1) begin
                            state    <= S_PAYLOAD;
                            idx      <= '0;
                            good_cnt <= 4'd1;
                            locked   <= locked || lock_hdr;
                            gate     <= PASS_UNLOCKED || locked || lock_hdr;
                        end else if (!is_hdr0) begin
                            state <= S_HUNT;
                        end
                    end
                    S_PAYLOAD: begin
                        // Gate was fixed at the header, so a frame is emitted whole or not at all
                        if (gate) begin
                            dout     <= din;
                            dout_vld <= 1'b1;
                            sof      <= (idx == '0);
                            eof      <= last_beat;
                            if (last_beat) frame_cnt <= frame_cnt + 16'd1;
                        end
                        if (last_beat) state <= S_EXP0;
                        else           idx   <= idx + CW'(1);
                    end
                    S_EXP0: begin
                        state <= is_hdr0 ? S_EXP1 : S_HUNT;
                    end
                    S_EXP1: begin
                        if (is_hdr1) begin
                            state    <= S_PAYLOAD;
                            idx      <= '0;
                            good_cnt <= good_inc;
                            miss_cnt <= '0;
                            locked   <= locked || lock_hdr;
                            gate     <= PASS_UNLOCKED || locked || lock_hdr;
                        end else begin
                            state <= is_hdr0 ? S_GOT0 : S_HUNT;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end
            if (miss) begin
                hdr_err  <= 1'b1;
                good_cnt <= '0;
                if (lock_drop) begin
                    locked   <= 1'b0;
                    miss_cnt <= '0;
                end else begin
                    miss_cnt <= miss_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// tb/tb_lvds_frame_aligner.sv - randomized scoreboard bench for lvds_frame_aligner (two parameter sets)
module tb_lvds_frame_aligner;

    localparam logic [7:0] H0 = 8'hEE;
    localparam logic [7:0] H1 = 8'h33;
    localparam int LOCK = 3;
    localparam int LOSS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;

    logic [7:0]  dout0, dout1;
    logic        vld0, vld1, sof0, sof1, eof0, eof1, lk0, lk1, err0, err1;
    logic [15:0] fc0, fc1;

    always #5 clk = ~clk;

    lvds_frame_aligner u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .dout(dout0), .dout_vld(vld0), .sof(sof0), .eof(eof0),
        .locked(lk0), .hdr_err(err0), .frame_cnt(fc0)
    );

    lvds_frame_aligner #(.PAYLOAD_LEN(1), .PASS_UNLOCKED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .dout(dout1), .dout_vld(vld1), .sof(sof1), .eof(eof1),
        .locked(lk1), .hdr_err(err1), .frame_cnt(fc1)
    );

    typedef struct {
        bit         vld;
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         err;
        bit         lk;
        logic [15:0] fc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int plen[2]  = '{124, 1};
    bit ppass[2] = '{1'b0, 1'b1};

    // Reference model: a frame is "remaining payload count" plus header expectation flags
    int rem[2], hpos[2], good[2], missc[2], fcnt[2];
    bit chained[2], saw0[2], lk[2], gate[2], prev_lk[2];

    int n_vec = 0;
    int n_err = 0;
    int gap_pct = 0;

    task automatic q_push(input int m, input ev_t e);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic int q_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_pop(input int m, output ev_t e);
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            rem[m] = 0; hpos[m] = 0; good[m] = 0; missc[m] = 0; fcnt[m] = 0;
            chained[m] = 0; saw0[m] = 0; lk[m] = 0; gate[m] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic take_header(input int m, input bit is_chain);
        if (is_chain) begin
            good[m]  = (good[m] + 1 > LOCK) ? LOCK : good[m] + 1;
            missc[m] = 0;
        end else begin
            good[m] = 1;
        end
        if (good[m] == LOCK) lk[m] = 1;
        gate[m]    = ppass[m] || lk[m];
        rem[m]     = plen[m];
        chained[m] = 0;
        saw0[m]    = 0;
    endtask

    task automatic model_step(input int m, input logic [7:0] s);
        ev_t e;
        bit  emit, missed, was_lk;
        int  pos;
        e = '{default: '0};
        emit = 0; missed = 0; was_lk = lk[m];
        if (rem[m] > 0) begin
            pos = plen[m] - rem[m];
            if (gate[m]) begin
                e.vld = 1; e.data = s; e.sof = (pos == 0); e.eof = (rem[m] == 1);
                if (e.eof) fcnt[m] = (fcnt[m] + 1) % 65536;
                emit = 1;
            end
            rem[m]--;
            if (rem[m] == 0) begin chained[m] = 1; hpos[m] = 0; end
        end else if (chained[m]) begin
            if (hpos[m] == 0) begin
                if (s == H0) hpos[m] = 1;
                else begin missed = 1; saw0[m] = 0; end
            end else if (s == H1) begin
                take_header(m, 1);
            end else begin
                missed = 1; saw0[m] = (s == H0);
            end
        end else if (saw0[m] && s == H1) begin
            take_header(m, 0);
        end else begin
            saw0[m] = (s == H0);
        end
        if (missed) begin
            chained[m] = 0;
            good[m]    = 0;
            missc[m]   = (missc[m] + 1 > LOSS) ? LOSS : missc[m] + 1;
            if (lk[m] && missc[m] == LOSS) begin lk[m] = 0; missc[m] = 0; end
            e.err = 1; emit = 1;
        end
        e.lk = lk[m];
        e.fc = 16'(fcnt[m]);
        if (lk[m] != was_lk) emit = 1;
        if (emit) q_push(m, e);
    endtask

    task automatic cmp(input string nm, input int m, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, m, act, exp, $time);
        end
    endtask

    task automatic mon(input int m, input logic v, input logic [7:0] d, input logic so, input logic eo,
                       input logic er, input logic l, input logic [15:0] fc);
        ev_t e;
        if (v || so || eo || er || (l != prev_lk[m])) begin
            if (q_size(m) == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_output dut%0d: got vld=%0b sof=%0b eof=%0b err=%0b locked=%0b, expected no event at %0t",
                         m, v, so, eo, er, l, $time);
            end else begin
                q_pop(m, e);
                cmp("dout_vld", m, 16'(v), 16'(e.vld));
                if (e.vld) cmp("dout", m, 16'(d), 16'(e.data));
                cmp("sof", m, 16'(so), 16'(e.sof));
                cmp("eof", m, 16'(eo), 16'(e.eof));
                cmp("hdr_err", m, 16'(er), 16'(e.err));
                cmp("locked", m, 16'(l), 16'(e.lk));
                cmp("frame_cnt", m, fc, e.fc);
            end
        end
        prev_lk[m] = l;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_lk[0] = 0;
                prev_lk[1] = 0;
            end else begin
                mon(0, vld0, dout0, sof0, eof0, err0, lk0, fc0);
                mon(1, vld1, dout1, sof1, eof1, err1, lk1, fc1);
            end
        end
    end

    task automatic send(input logic [7:0] s);
        while ($urandom_range(99) < 32'(gap_pct)) begin
            @(negedge clk);
            din_vld = 1'b0;
            din     = 8'($urandom);
        end
        @(negedge clk);
        din     = s;
        din_vld = 1'b1;
        model_step(0, s);
        model_step(1, s);
    endtask

    task automatic send_frame(input int nbytes);
        send(H0);
        send(H1);
        for (int i = 0; i < nbytes; i++) send(8'($urandom));
    endtask

    task automatic chk_idle(input string tag);
        cmp({tag, "_dout"}, 0, 16'(dout0), 16'h0);
        cmp({tag, "_vld"}, 0, 16'(vld0), 16'h0);
        cmp({tag, "_sof"}, 0, 16'(sof0), 16'h0);
        cmp({tag, "_eof"}, 0, 16'(eof0), 16'h0);
        cmp({tag, "_locked"}, 0, 16'(lk0), 16'h0);
        cmp({tag, "_hdr_err"}, 0, 16'(err0), 16'h0);
        cmp({tag, "_fcnt"}, 0, fc0, 16'h0);
        cmp({tag, "_dout"}, 1, 16'(dout1), 16'h0);
        cmp({tag, "_vld"}, 1, 16'(vld1), 16'h0);
        cmp({tag, "_locked"}, 1, 16'(lk1), 16'h0);
        cmp({tag, "_fcnt"}, 1, fc1, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_idle("reset");
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        prev_lk[0] = 0;
        prev_lk[1] = 0;
        repeat (3) @(negedge clk);
        #1 chk_idle("por");
        #1 rst_n = 1'b1;

        // lock up, then reset mid-payload while emitting
        for (int f = 0; f < 4; f++) send_frame(124);
        send_frame(20);
        do_reset();

        // free header after reset, then chained frames, single miss, re-hunt, second miss
        send_frame(124);
        for (int f = 0; f < 3; f++) send_frame(124);
        send(8'hAA); send(8'hBB);
        send_frame(124);
        send(8'hAA); send(8'hBB);
        for (int f = 0; f < 3; f++) send_frame(124);

        // 50% input gaps across header and payload
        gap_pct = 50;
        for (int f = 0; f < 4; f++) send_frame(124);
        gap_pct = 0;

        // GOT0 self-loop and broken header
        send(8'h00); send(H0); send(H0); send(H1);
        for (int i = 0; i < 124; i++) send(8'($urandom));
        send(8'h12); send(H0); send(8'h12); send(H1);
        send(H0); send(H1); send(8'h5A);

        // random soup biased toward header symbols
        gap_pct = 25;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0:       send(H0);
                1:       send(H1);
                default: send(8'($urandom));
            endcase
        end
        gap_pct = 0;

        @(negedge clk);
        din_vld = 1'b0;
        for (int i = 0; i < 100 && (q_size(0) + q_size(1)) > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        cmp("pending_events", 0, 16'(q_size(0)), 16'h0);
        cmp("pending_events", 1, 16'(q_size(1)), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
